// File: rtl/bitfusion_pkg.sv
// Shared constants and types for the bit-fusion accumulator back end.
package bitfusion_pkg;

  localparam int ACC_W   = 28;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;
  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  // Outcome of the saturation stage for one result
  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HIGH = 2'd1,
    SAT_LOW  = 2'd2
  } sat_e;

endpackage

// File: rtl/acc_requant_if.sv
// Accumulator-side and activation-side handshake bundle for acc_requant.
interface acc_requant_if #(
  parameter int ACC_W   = bitfusion_pkg::ACC_W,
  parameter int OUT_W   = bitfusion_pkg::OUT_W,
  parameter int SHIFT_W = bitfusion_pkg::SHIFT_W
);

  logic signed [ACC_W-1:0]   acc_in;
  logic                      acc_valid;
  logic                      acc_ready;
  logic        [SHIFT_W-1:0] shift_amt;
  logic                      relu_en;
  logic        [OUT_W-1:0]   out_data;
  logic                      out_valid;
  logic                      out_ready;

  // Producer of accumulations and consumer of activations
  modport master (
    output acc_in, acc_valid, shift_amt, relu_en, out_ready,
    input  acc_ready, out_data, out_valid
  );

  // The requantizer itself
  modport slave (
    input  acc_in, acc_valid, shift_amt, relu_en, out_ready,
    output acc_ready, out_data, out_valid
  );

endinterface

// File: rtl/requant_fifo.sv
// Small circular FIFO holding requantized activations; head is read straight
// from the storage registers so dout is stable while the FIFO is idle.
module requant_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & ((count < FULL_COUNT) | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; cleared on reset so the idle head reads as zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Upstream flow control guarantees a push never meets a full FIFO
  assert property (@(posedge clk) disable iff (reset)
    push |-> ((count < FULL_COUNT) || do_pop));

endmodule

// File: rtl/acc_requant.sv
// Captures finished accumulations, clears the accumulator, and requantizes
// each value (ReLU, rounding shift, signed saturation) into an 8-bit
// activation queued in a small output FIFO.
module acc_requant #(
  parameter int ACC_W = bitfusion_pkg::ACC_W,
  parameter int OUT_W = bitfusion_pkg::OUT_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  acc_requant_if.slave bus,
  output logic         acc_clear,
  output logic         sat_flag,
  output logic [7:0]   sat_cnt
);

  localparam int SHIFT_W = bitfusion_pkg::SHIFT_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  // Saturation bounds expressed at the widened datapath width
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_LO = -SAT_HI - (ACC_W + 1)'(1);

  logic                      accept;
  logic                      s1_valid;
  logic signed [ACC_W-1:0]   s1_acc;
  logic        [SHIFT_W-1:0] s1_shift;
  logic                      s1_relu;

  logic signed [ACC_W:0]     relu_val;
  logic signed [ACC_W:0]     round_bias;
  logic signed [ACC_W:0]     rounded;
  bitfusion_pkg::sat_e       sat_kind;
  logic        [OUT_W-1:0]   result;

  logic        [CNT_W-1:0]   fifo_count;
  logic                      fifo_empty;
  logic                      fifo_pop;

  // Space is reserved for the result already in stage 1, so the FIFO can
  // never overflow; only registered state feeds this decision.
  assign bus.acc_ready = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid})
                         < (CNT_W + 1)'(DEPTH);
  assign accept        = bus.acc_valid & bus.acc_ready;

  // Stage 1: capture the accumulation with its shift/ReLU settings and pulse the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_acc    <= '0;
      s1_shift  <= '0;
      s1_relu   <= 1'b0;
      acc_clear <= 1'b0;
    end else begin
      s1_valid  <= accept;
      acc_clear <= accept;
      if (accept) begin
        s1_acc   <= bus.acc_in;
        s1_shift <= bus.shift_amt;
        s1_relu  <= bus.relu_en;
      end
    end
  end

  // ReLU then round-half-up arithmetic shift, one bit wider than the input
  always_comb begin
    relu_val   = {s1_acc[ACC_W-1], s1_acc};
    if (s1_relu && s1_acc[ACC_W-1]) begin
      relu_val = '0;
    end
    round_bias = '0;
    rounded    = relu_val;
    if (s1_shift != '0) begin
      round_bias = (ACC_W + 1)'(1) << (s1_shift - SHIFT_W'(1));
      rounded    = (relu_val + round_bias) >>> s1_shift;
    end
  end

  // Clamp to the signed output range and classify the outcome
  always_comb begin
    sat_kind = bitfusion_pkg::SAT_NONE;
    result   = rounded[OUT_W-1:0];
    if (rounded > SAT_HI) begin
      sat_kind = bitfusion_pkg::SAT_HIGH;
      result   = SAT_HI[OUT_W-1:0];
    end else if (rounded < SAT_LO) begin
      sat_kind = bitfusion_pkg::SAT_LOW;
      result   = SAT_LO[OUT_W-1:0];
    end
  end

  // Sticky saturation flag and a counter that parks at its maximum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag <= 1'b0;
      sat_cnt  <= 8'd0;
    end else if (s1_valid && (sat_kind != bitfusion_pkg::SAT_NONE)) begin
      sat_flag <= 1'b1;
      if (sat_cnt != 8'hFF) begin
        sat_cnt <= sat_cnt + 8'd1;
      end
    end
  end

  assign fifo_pop      = bus.out_valid & bus.out_ready;
  assign bus.out_valid = ~fifo_empty;

  requant_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s1_valid),
    .pop   (fifo_pop),
    .din   (result),
    .dout  (bus.out_data),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_acc_requant.sv
// Randomized, self-checking bench for acc_requant with a real-arithmetic
// reference model of ReLU, round-half-up shift and saturation.
module tb_acc_requant;

  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  logic       clk = 1'b0;
  logic       reset;
  logic       acc_clear;
  logic       sat_flag;
  logic [7:0] sat_cnt;

  acc_requant_if bus ();

  acc_requant dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .acc_clear (acc_clear),
    .sat_flag  (sat_flag),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int got_q[$];
  int exp_sat_cnt;
  bit exp_sat_flag;
  int n_accepts;
  int n_clears;

  // Reference: clamp negatives if asked, divide by 2^s, round half toward +inf, clamp
  function automatic int ref_result(input longint x, input int s, input bit relu, output bit sat);
    real    v;
    longint q;
    v = (relu && x < 0) ? 0.0 : real'(x);
    if (s == 0) q = longint'(v);
    else        q = longint'($floor(v / (2.0 ** s) + 0.5));
    sat = 1'b1;
    if (q > OUT_MAX) return OUT_MAX;
    if (q < OUT_MIN) return OUT_MIN;
    sat = 1'b0;
    return int'(q);
  endfunction

  task automatic clear_books();
    exp_q.delete();
    got_q.delete();
    n_accepts = 0;
    n_clears  = 0;
  endtask

  // One clock: log handshakes that complete at the coming edge, then step past it
  task automatic cycle();
    bit acc_now;
    bit pop_now;
    bit sat;
    int r;
    acc_now = bus.acc_valid && bus.acc_ready;
    pop_now = bus.out_valid && bus.out_ready;
    if (pop_now) got_q.push_back(int'($signed(bus.out_data)));
    if (acc_now) begin
      r = ref_result(longint'(bus.acc_in), int'(bus.shift_amt), bus.relu_en, sat);
      exp_q.push_back(r);
      n_accepts++;
      if (sat) begin
        exp_sat_flag = 1'b1;
        if (exp_sat_cnt < 255) exp_sat_cnt++;
      end
    end
    @(posedge clk);
    #1;
    if (acc_clear === 1'b1) n_clears++;
  endtask

  task automatic drive_acc(input int x, input int s, input bit relu);
    bus.acc_valid = 1'b1;
    bus.acc_in    = 28'(x);
    bus.shift_amt = 5'(s);
    bus.relu_en   = relu;
  endtask

  task automatic send_one(input int x, input int s, input bit relu, output bit ok);
    int waited;
    bit took;
    drive_acc(x, s, relu);
    waited = 0;
    took   = 1'b0;
    while (!took && waited < 20) begin
      took = bus.acc_ready;
      cycle();
      waited++;
    end
    bus.acc_valid = 1'b0;
    ok = took;
  endtask

  task automatic apply_reset();
    bus.acc_valid = 1'b0;
    bus.acc_in    = '0;
    bus.shift_amt = '0;
    bus.relu_en   = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_sat_cnt  = 0;
    exp_sat_flag = 1'b0;
    clear_books();
  endtask

  function automatic int rand_acc();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 4000)) - 2000;
    return int'($urandom_range(0, 32'h0FFF_FFFF)) - (1 << 27);
  endfunction

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_acc_ready: got %b want 1", bus.acc_ready); end
    checks++; if (acc_clear !== 1'b0) begin errors++; $display("[TB] FAIL reset_acc_clear: got %b want 0", acc_clear); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_out_data: got %0h want 0", bus.out_data); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat_flag: got %b want 0", sat_flag); end
    checks++; if (sat_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_sat_cnt: got %0d want 0", sat_cnt); end
  endtask

  task automatic test_single();
    clear_books();
    bus.out_ready = 1'b0;
    drive_acc(1000, 3, 1'b0);
    checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b want 1", bus.acc_ready); end
    cycle();
    bus.acc_valid = 1'b0;
    checks++; if (acc_clear !== 1'b1) begin errors++; $display("[TB] FAIL single_clear_n1: got %b want 1", acc_clear); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_n1: got %b want 0", bus.out_valid); end
    cycle();
    checks++; if (acc_clear !== 1'b0) begin errors++; $display("[TB] FAIL single_clear_n2: got %b want 0", acc_clear); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid_n2: got %b want 1", bus.out_valid); end
    checks++; if (int'($signed(bus.out_data)) != 125) begin errors++; $display("[TB] FAIL single_data: got %0d want 125", $signed(bus.out_data)); end
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_rounding();
    int dx[3]   = '{-20, -20, -3};
    int ds[3]   = '{2, 2, 1};
    bit dr[3]   = '{1'b0, 1'b1, 1'b0};
    int dexp[3] = '{-5, 0, -1};
    int timeouts;
    int bad;
    int guard;
    bit ok;
    clear_books();
    bus.out_ready = 1'b1;
    timeouts = 0;
    for (int i = 0; i < 3; i++) begin
      send_one(dx[i], ds[i], dr[i], ok);
      if (!ok) timeouts++;
    end
    for (int i = 0; i < 40; i++) begin
      send_one(rand_acc(), int'($urandom_range(0, 27)), 1'($urandom_range(0, 1)), ok);
      if (!ok) timeouts++;
    end
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 20) begin cycle(); guard++; end
    repeat (2) cycle();
    checks++; if (timeouts != 0) begin errors++; $display("[TB] FAIL round_accept_timeout: got %0d timeouts want 0", timeouts); end
    checks++; if (got_q.size() != 43) begin errors++; $display("[TB] FAIL round_count: got %0d want 43", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) begin
        checks++; if (got_q[i] != dexp[i]) begin errors++; $display("[TB] FAIL round_directed[%0d]: got %0d want %0d", i, got_q[i], dexp[i]); end
      end
    end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] != exp_q[i]) begin
        bad++;
        $display("[TB] FAIL round_model[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
      end
    end
    checks++; if (bad != 0) errors++;
    checks++; if (sat_cnt !== 8'(exp_sat_cnt)) begin errors++; $display("[TB] FAIL round_sat_cnt: got %0d want %0d", sat_cnt, exp_sat_cnt); end
    checks++; if (sat_flag !== exp_sat_flag) begin errors++; $display("[TB] FAIL round_sat_flag: got %b want %b", sat_flag, exp_sat_flag); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    bit ok;
    int bad;
    int x;
    apply_reset();
    bus.out_ready = 1'b1;
    send_one(32'h07FF_FFFF, 0, 1'b0, ok);
    repeat (3) cycle();
    checks++; if (got_q.size() < 1 || got_q[0] != 127) begin errors++; $display("[TB] FAIL sat_high: got %0d want 127", (got_q.size() > 0) ? got_q[0] : -999); end
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("[TB] FAIL sat_flag_set: got %b want 1", sat_flag); end
    checks++; if (sat_cnt !== 8'd1) begin errors++; $display("[TB] FAIL sat_cnt_1: got %0d want 1", sat_cnt); end
    send_one(-200000, 4, 1'b0, ok);
    repeat (3) cycle();
    checks++; if (got_q.size() < 2 || got_q[1] != -128) begin errors++; $display("[TB] FAIL sat_low: got %0d want -128", (got_q.size() > 1) ? got_q[1] : -999); end
    checks++; if (sat_cnt !== 8'd2) begin errors++; $display("[TB] FAIL sat_cnt_2: got %0d want 2", sat_cnt); end
    for (int i = 0; i < 300; i++) begin
      x = int'($urandom_range(200, 100000));
      if ($urandom_range(0, 1) == 1) x = -x;
      drive_acc(x, 0, 1'b0);
      cycle();
    end
    bus.acc_valid = 1'b0;
    repeat (4) cycle();
    checks++; if (sat_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_cnt_hold: got %0d want 255", sat_cnt); end
    checks++; if (n_accepts != 302) begin errors++; $display("[TB] FAIL sat_accepts: got %0d want 302", n_accepts); end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] != exp_q[i]) bad++;
    checks++; if (bad != 0 || got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL sat_stream: got %0d wrong of %0d outputs want 0 wrong of %0d", bad, got_q.size(), exp_q.size()); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int guard;
    int bad;
    clear_books();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_acc(rand_acc(), int'($urandom_range(0, 27)), 1'($urandom_range(0, 1)));
      cycle();
    end
    checks++; if (n_accepts != 4) begin errors++; $display("[TB] FAIL bp_accepts: got %0d want 4", n_accepts); end
    checks++; if (bus.acc_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low: got %b want 0", bus.acc_ready); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid: got %b want 1", bus.out_valid); end
    bus.acc_valid = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_return: got %b want 1", bus.acc_ready); end
    guard = 0;
    while (got_q.size() < 4 && guard < 20) begin cycle(); guard++; end
    checks++; if (got_q.size() != 4) begin errors++; $display("[TB] FAIL bp_drain_count: got %0d want 4", got_q.size()); end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] != exp_q[i]) begin
        bad++;
        $display("[TB] FAIL bp_order[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
      end
    end
    checks++; if (bad != 0) errors++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int max_count;
    int ready_drops;
    int bad;
    clear_books();
    bus.out_ready = 1'b1;
    max_count   = 0;
    ready_drops = 0;
    for (int i = 0; i < 16; i++) begin
      drive_acc(rand_acc(), int'($urandom_range(0, 27)), 1'($urandom_range(0, 1)));
      if (bus.acc_ready !== 1'b1) ready_drops++;
      cycle();
      if (int'(dut.u_fifo.count) > max_count) max_count = int'(dut.u_fifo.count);
    end
    bus.acc_valid = 1'b0;
    repeat (2) begin
      cycle();
      if (int'(dut.u_fifo.count) > max_count) max_count = int'(dut.u_fifo.count);
    end
    checks++; if (ready_drops != 0) begin errors++; $display("[TB] FAIL b2b_ready_drops: got %0d want 0", ready_drops); end
    checks++; if (got_q.size() != 16) begin errors++; $display("[TB] FAIL b2b_throughput: got %0d outputs want 16", got_q.size()); end
    checks++; if (n_clears != 16) begin errors++; $display("[TB] FAIL b2b_clears: got %0d want 16", n_clears); end
    checks++; if (max_count > 2) begin errors++; $display("[TB] FAIL b2b_fifo_depth: got %0d want at most 2", max_count); end
    checks++; if (acc_clear !== 1'b0) begin errors++; $display("[TB] FAIL b2b_clear_idle: got %b want 0", acc_clear); end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] != exp_q[i]) begin
        bad++;
        $display("[TB] FAIL b2b_order[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
      end
    end
    checks++; if (bad != 0) errors++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    clear_books();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_acc(rand_acc(), int'($urandom_range(0, 27)), 1'b0);
      cycle();
    end
    bus.acc_valid = 1'b0;
    checks++; if (acc_clear !== 1'b1) begin errors++; $display("[TB] FAIL arst_clear_before: got %b want 1", acc_clear); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (acc_clear !== 1'b0) begin errors++; $display("[TB] FAIL arst_acc_clear: got %b want 0", acc_clear); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_sat_cnt  = 0;
    exp_sat_flag = 1'b0;
    clear_books();
    checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst_ready: got %b want 1", bus.acc_ready); end
    bus.out_ready = 1'b1;
    repeat (4) cycle();
    checks++; if (got_q.size() != 0) begin errors++; $display("[TB] FAIL arst_stale: got %0d outputs want 0", got_q.size()); end
    checks++; if (sat_cnt !== 8'd0) begin errors++; $display("[TB] FAIL arst_sat_cnt: got %0d want 0", sat_cnt); end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
